// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST: FSM states, operand table,
// MISR seed/taps and vector count.
package alu_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int          NUM_OPS     = 16;
  localparam int          NUM_PAIRS_D = 7;
  localparam int          NUM_VECTORS = NUM_PAIRS_D * NUM_OPS;
  localparam logic [31:0] SEED_D      = 32'hFFFF_FFFF;

  // x^32 + x^22 + x^2 + x + 1, seen as feedback taps on the shifted-out bits
  localparam int TAP0 = 31;
  localparam int TAP1 = 21;
  localparam int TAP2 = 1;
  localparam int TAP3 = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
  } vec_t;

  // Vector idx -> operand pair idx/16, opcode idx%16.
  function automatic vec_t get_vec(input logic [6:0] idx);
    vec_t v;
    v.aluc = idx[3:0];
    case (idx[6:4])
      3'd0:    begin v.a = 32'h0000_0000; v.b = 32'h0000_0000; end
      3'd1:    begin v.a = 32'h0000_0020; v.b = 32'h0000_0040; end
      3'd2:    begin v.a = 32'hFFFF_FFE0; v.b = 32'h0000_0020; end
      3'd3:    begin v.a = 32'hFFFF_FFE0; v.b = 32'h0000_0040; end
      3'd4:    begin v.a = 32'h0000_0020; v.b = 32'hFFFF_FFC0; end
      3'd5:    begin v.a = 32'h7FFF_FFFF; v.b = 32'h0000_0001; end
      3'd6:    begin v.a = 32'h0000_0000; v.b = 32'h0000_0001; end
      default: begin v.a = 32'h0000_0000; v.b = 32'h0000_0000; end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] data);
    return {sig[30:0], sig[TAP0] ^ sig[TAP1] ^ sig[TAP2] ^ sig[TAP3]} ^ data;
  endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// 32-bit multiple-input signature register; init reloads the seed, en
// folds one data word per clock.
module alu_bist_misr
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED = SEED_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sig <= SEED;
    else if (init) sig <= SEED;
    else if (en)   sig <= misr_next(sig, data);
  end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self test: sweeps operand pairs x 16 opcodes into an external
// ALU, compresses result+flags in a MISR and compares against golden.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          NUM_PAIRS = 7,
  parameter logic [31:0] SEED      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] golden,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [6:0]  vec_index
);

  localparam int         NVEC = NUM_PAIRS * NUM_OPS;
  localparam logic [6:0] LAST = 7'(NVEC - 1);

  state_t      state, state_nxt;
  vec_t        vec_nxt;
  logic [6:0]  idx_nxt;
  logic        busy_nxt, done_nxt, pass_nxt;
  logic        misr_init, misr_en;
  logic [31:0] misr_data;

  assign misr_data = alu_result ^ {28'b0, alu_zero, alu_carry, alu_negative, alu_overflow};

  alu_bist_misr #(.SEED(SEED)) u_misr (
    .clk  (clk),
    .rst  (rst),
    .init (misr_init),
    .en   (misr_en),
    .data (misr_data),
    .sig  (signature)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_aluc  <= '0;
      vec_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      alu_a     <= vec_nxt.a;
      alu_b     <= vec_nxt.b;
      alu_aluc  <= vec_nxt.aluc;
      vec_index <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = vec_index;
    vec_nxt.a    = alu_a;
    vec_nxt.b    = alu_b;
    vec_nxt.aluc = alu_aluc;
    busy_nxt     = busy;
    done_nxt     = done;
    pass_nxt     = pass;
    misr_init    = 1'b0;
    misr_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          vec_nxt   = get_vec(7'd0);
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          misr_init = 1'b1;
        end
      end
      RUN: begin
        misr_en = 1'b1;
        if (vec_index == LAST) begin
          // Operands stay on the last vector; golden is only looked at here.
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (misr_next(signature, misr_data) == golden);
        end else begin
          idx_nxt = vec_index + 7'd1;
          vec_nxt = get_vec(idx_nxt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU in the loop, signature model built from
// the operand table and MISR polynomial, randomized result corruption/golden.
module tb_alu_bist;

  localparam logic [31:0] SEED  = 32'hFFFF_FFFF;
  localparam int          NVEC  = 112;
  localparam logic [31:0] TAPMASK = 32'h8020_0003;

  logic        clk, rst, start;
  logic [31:0] golden;
  logic [31:0] alu_a, alu_b, alu_result, signature;
  logic [3:0]  alu_aluc;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;
  logic        busy, done, pass;
  logic [6:0]  vec_index;

  logic [31:0] flip;
  logic        stuck0;
  int          n_cmp, n_err;

  typedef struct packed {
    logic [31:0] r;
    logic        z, c, n, o;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] op);
    alu_out_t   q;
    logic [32:0] w;
    q = '0;
    w = '0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; q.r = w[31:0]; q.c = w[32];
                   q.o = (a[31] == b[31]) && (q.r[31] != a[31]); end
      4'd1:  begin w = {1'b0, a} - {1'b0, b}; q.r = w[31:0]; q.c = w[32];
                   q.o = (a[31] != b[31]) && (q.r[31] != a[31]); end
      4'd2:  q.r = a & b;
      4'd3:  q.r = a | b;
      4'd4:  q.r = a ^ b;
      4'd5:  q.r = ~(a | b);
      4'd6:  q.r = a << b[4:0];
      4'd7:  q.r = a >> b[4:0];
      4'd8:  q.r = $signed(a) >>> b[4:0];
      4'd9:  q.r = {31'b0, $signed(a) < $signed(b)};
      4'd10: q.r = {31'b0, a < b};
      4'd11: q.r = {b[15:0], 16'b0};
      4'd12: q.r = a * b;
      4'd13: q.r = a + 32'd1;
      4'd14: q.r = b;
      default: q.r = ~a;
    endcase
    q.z = (q.r == 32'd0);
    q.n = q.r[31];
    return q;
  endfunction

  alu_out_t fo;
  assign fo           = alu_ref(alu_a, alu_b, alu_aluc);
  assign alu_result   = (fo.r ^ flip) | {31'b0, stuck0};
  assign alu_zero     = fo.z;
  assign alu_carry    = fo.c;
  assign alu_negative = fo.n;
  assign alu_overflow = fo.o;

  alu_bist dut (
    .clk(clk), .rst(rst), .start(start), .golden(golden),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .busy(busy), .done(done), .pass(pass),
    .signature(signature), .vec_index(vec_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand table as written in the requirements, in signed decimal.
  function automatic logic [31:0] pa(input int p);
    int t[7] = '{0, 32, -32, -32, 32, 32'h7FFF_FFFF, 0};
    return t[p];
  endfunction
  function automatic logic [31:0] pb(input int p);
    int t[7] = '{0, 64, 32, 64, -64, 1, 1};
    return t[p];
  endfunction

  function automatic logic [31:0] vec_data(input int k);
    alu_out_t q;
    q = alu_ref(pa(k / 16), pb(k / 16), 4'(k % 16));
    return ((q.r ^ flip) | {31'b0, stuck0}) ^ {28'b0, q.z, q.c, q.n, q.o};
  endfunction

  // Shift left, feed back the parity of the tapped bits, then add data.
  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] d);
    return ((s << 1) | {31'b0, ^(s & TAPMASK)}) ^ d;
  endfunction

  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] s;
    s = SEED;
    for (int k = 0; k < n; k++) s = mstep(s, vec_data(k));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_aluc", 32'(alu_aluc), 0);
    chk("rst_vec", 32'(vec_index), 0);
    chk("rst_sig", signature, SEED);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
  endtask

  // Start a run (start held for 'hold' cycles after sampling), check every
  // cycle, optionally abort with reset when vector abort_at is driven.
  task automatic run(input logic [31:0] gold, input int hold, input int abort_at,
                     output logic [31:0] fsig);
    logic [31:0] s;
    logic        exp_pass;
    s        = SEED;
    exp_pass = (gold == model_sig(NVEC));
    golden   = gold;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NVEC; k++) begin
      if (k >= hold) start = 1'b0;
      chk("vec_index", 32'(vec_index), k);
      chk("alu_a", alu_a, pa(k / 16));
      chk("alu_b", alu_b, pb(k / 16));
      chk("alu_aluc", 32'(alu_aluc), k % 16);
      chk("sig_run", signature, s);
      chk("busy_run", 32'(busy), 1);
      chk("done_run", 32'(done), 0);
      chk("pass_run", 32'(pass), 0);
      if (k == 17) begin
        chk("v17_a", alu_a, 32'd32);
        chk("v17_b", alu_b, 32'd64);
        chk("v17_aluc", 32'(alu_aluc), 1);
      end
      if (k == 80) begin
        chk("v80_a", alu_a, 32'h7FFF_FFFF);
        chk("v80_b", alu_b, 32'd1);
        chk("v80_aluc", 32'(alu_aluc), 0);
      end
      if (k == abort_at) begin
        #1 rst = 1'b1;
        #1 check_reset();
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        fsig  = signature;
        return;
      end
      s = mstep(s, vec_data(k));
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_end", 32'(done), 1);
    chk("busy_end", 32'(busy), 0);
    chk("sig_end", signature, s);
    chk("pass_end", 32'(pass), 32'(exp_pass));
    chk("vec_end", 32'(vec_index), NVEC - 1);
    chk("a_end", alu_a, 32'd0);
    chk("b_end", alu_b, 32'd1);
    chk("aluc_end", 32'(alu_aluc), 15);
    fsig = signature;
    repeat (2) @(negedge clk);
    chk("done_hold", 32'(done), 1);
    chk("sig_hold", signature, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s1, s2, s3, g;
    n_cmp  = 0;
    n_err  = 0;
    flip   = '0;
    stuck0 = 1'b0;
    start  = 1'b0;
    golden = '0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();

    // Fault-free, start held high well into the run.
    g = model_sig(NVEC);
    run(g, $urandom_range(2, 100), -1, s1);
    chk("pass_good", 32'(pass), 1);

    // Restart straight from DONE; done must fall on the sampling edge.
    run(g, 1, -1, s2);
    chk("restart_sig", s2, s1);

    // Result bit 0 stuck at 1 against the fault-free golden.
    stuck0 = 1'b1;
    run(g, 1, -1, s3);
    chk("pass_stuck", 32'(pass), 0);
    stuck0 = 1'b0;

    // Asynchronous reset mid-cycle while in DONE.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset();
    @(negedge clk);
    rst = 1'b0;

    // Abort at vector 50, then an uninterrupted run must match s1.
    run(g, 1, 50, s3);
    repeat (2) @(negedge clk);
    check_reset();
    run(g, $urandom_range(1, 40), -1, s3);
    chk("abort_sig", s3, s1);
    chk("pass_abort", 32'(pass), 1);

    // Random result corruption, golden either matching or random.
    for (int r = 0; r < 4; r++) begin
      flip = $urandom;
      g    = ($urandom_range(0, 1) == 1) ? model_sig(NVEC) : $urandom;
      run(g, $urandom_range(1, 100), -1, s3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
